// File: rtl/dcm_lock_seq.sv
// DCM power-up/recovery sequencer: pulses DCM reset, waits for lock with timeout
// and bounded retries, and requires a stable lock interval before releasing sys_rst_n.
module dcm_lock_seq #(
    parameter int RST_HOLD_CYCLES = 4,
    parameter int LOCK_TIMEOUT    = 1048576,
    parameter int STABLE_CYCLES   = 16,
    parameter int MAX_RETRIES     = 3,
    parameter int CNT_W           = 21
) (
    input  logic       GLBclk,
    input  logic       reset,
    input  logic       dcm_locked,
    output logic       dcm_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(RST_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] ST_LIM   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [1:0]       MAX_R    = 2'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             sync1_q, locked_s_q;
    logic             dcm_rst_q, sys_rst_n_q, ready_q, fail_q;
    logic             dcm_rst_d, sys_rst_n_d, ready_d, fail_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        retry_d = retry_q;
        unique case (state_q)
            S_HOLD: begin
                if (cnt_q >= HOLD_LIM) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // A lock seen on the timeout cycle wins over the retry.
                if (locked_s_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q >= TO_LIM) begin
                    cnt_d = '0;
                    if (retry_q >= MAX_R) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_HOLD;
                        retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s_q) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q >= ST_LIM) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = 2'd0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!locked_s_q) state_d = S_HOLD;
            end
            S_FAIL: cnt_d = '0;
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the current state, so they trail it by one edge.
    always_comb begin
        dcm_rst_d   = (state_q == S_HOLD) || (state_q == S_FAIL);
        sys_rst_n_d = (state_q == S_RUN);
        ready_d     = (state_q == S_RUN);
        fail_d      = (state_q == S_FAIL);
    end

    always_ff @(posedge GLBclk) begin
        if (!reset) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            retry_q     <= 2'd0;
            sync1_q     <= 1'b0;
            locked_s_q  <= 1'b0;
            dcm_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sync1_q     <= dcm_locked;
            locked_s_q  <= sync1_q;
            dcm_rst_q   <= dcm_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign dcm_rst   = dcm_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_dcm_lock_seq.sv
// Directed bench for dcm_lock_seq: per-edge expectations go through a scoreboard queue.
module tb_dcm_lock_seq;

    logic       GLBclk = 1'b0;
    logic       reset;
    logic       dcm_locked;
    logic       dcm_rst, sys_rst_n, ready, fail;
    logic [1:0] retry_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic       dr, sr, rdy, fl;
        logic [1:0] rc;
    } exp_t;

    exp_t sbq[$];

    dcm_lock_seq #(
        .RST_HOLD_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8),
        .MAX_RETRIES(2), .CNT_W(21)
    ) dut (
        .GLBclk(GLBclk), .reset(reset), .dcm_locked(dcm_locked),
        .dcm_rst(dcm_rst), .sys_rst_n(sys_rst_n), .ready(ready),
        .fail(fail), .retry_cnt(retry_cnt)
    );

    always #5 GLBclk = ~GLBclk;

    task automatic chk(input string tag, input string fld, input int e,
                       input logic [1:0] act, input logic [1:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s.%s edge %0d: got %0d expected %0d", tag, fld, e, act, exp);
        end
    endtask

    // Push the expectation, advance one edge, sample 1ns later and compare.
    task automatic cycle(input string tag, input int e, input logic dr, input logic sr,
                         input logic rdy, input logic fl, input logic [1:0] rc);
        exp_t x;
        x.tag = tag; x.dr = dr; x.sr = sr; x.rdy = rdy; x.fl = fl; x.rc = rc;
        sbq.push_back(x);
        @(posedge GLBclk);
        #1;
        x = sbq.pop_front();
        chk(x.tag, "dcm_rst",   e, {1'b0, dcm_rst},   {1'b0, x.dr});
        chk(x.tag, "sys_rst_n", e, {1'b0, sys_rst_n}, {1'b0, x.sr});
        chk(x.tag, "ready",     e, {1'b0, ready},     {1'b0, x.rdy});
        chk(x.tag, "fail",      e, {1'b0, fail},      {1'b0, x.fl});
        chk(x.tag, "retry_cnt", e, retry_cnt,         x.rc);
    endtask

    task automatic rst_cycles(input string tag, input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) cycle(tag, i, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        logic sr, dr, fl;
        logic [1:0] rc;
        reset      = 1'b0;
        dcm_locked = 1'b0;
        #2;

        rst_cycles("reset_vals", 3);

        // Clean lock: release at edge 0, lock sampled at edge 10.
        reset = 1'b1;
        for (int e = 0; e <= 23; e++) begin
            if (e == 10) dcm_locked = 1'b1;
            sr = (e >= 21);
            cycle("clean_lock", e, (e <= 4), sr, sr, 1'b0, 2'd0);
        end

        // Loss of lock at local edge 0, relock at local edge 10.
        for (int e = 0; e <= 22; e++) begin
            if (e == 0)  dcm_locked = 1'b0;
            if (e == 10) dcm_locked = 1'b1;
            sr = (e <= 2) || (e >= 21);
            cycle("lock_loss", e, (e >= 3 && e <= 7), sr, sr, 1'b0, 2'd0);
        end

        // Reset while in RUN.
        dcm_locked = 1'b0;
        rst_cycles("rst_in_run", 2);

        // Glitchy lock: high 5, low 3, then high for good from edge 16.
        reset = 1'b1;
        for (int e = 0; e <= 28; e++) begin
            dcm_locked = (e >= 8 && e <= 12) || (e >= 16);
            sr = (e >= 27);
            cycle("glitch", e, (e <= 4), sr, sr, 1'b0, 2'd0);
        end

        // Reset during STABLE with dcm_locked held high, then full restart.
        rst_cycles("rst_in_run2", 1);
        reset = 1'b1;
        for (int e = 0; e <= 8; e++) cycle("to_stable", e, (e <= 4), 1'b0, 1'b0, 1'b0, 2'd0);
        rst_cycles("rst_in_stable", 1);
        reset = 1'b1;
        for (int e = 0; e <= 15; e++) begin
            sr = (e >= 14);
            cycle("restart", e, (e <= 4), sr, sr, 1'b0, 2'd0);
        end

        // No lock ever: two retries, then FAIL on the third timeout.
        dcm_locked = 1'b0;
        rst_cycles("rst_pre_fail", 1);
        reset = 1'b1;
        for (int e = 0; e <= 85; e++) begin
            dr = (e <= 4) || (e >= 26 && e <= 30) || (e >= 52 && e <= 56) || (e >= 78);
            fl = (e >= 78);
            rc = (e >= 51) ? 2'd2 : (e >= 25) ? 2'd1 : 2'd0;
            cycle("retries", e, dr, 1'b0, 1'b0, fl, rc);
        end
        rst_cycles("fail_clear", 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcm_lock_seq.md
# dcm_lock_seq

Power-up and recovery sequencer for the board DCM that produces clkD16 and clk50M on the Spartan-3 seven-segment design. It pulses the DCM reset, waits for LOCKED with a timeout and bounded retries, and requires a stable lock interval before releasing the system reset. On loss of lock it pulls the system reset and restarts the sequence. Everything runs on GLBclk, the DCM input clock, so the block keeps working while the DCM outputs are absent.

## Interface
- RST_HOLD_CYCLES, 4: GLBclk cycles dcm_rst is held high after reset release (DCM needs ≥3).
- LOCK_TIMEOUT, 1048576: WAIT_LOCK cycles allowed before a retry.
- STABLE_CYCLES, 16: consecutive synchronized-lock cycles required before release.
- MAX_RETRIES, 3: timeouts tolerated per sequence; the next timeout enters FAIL.
- CNT_W, 21: counter width; must hold max(RST_HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- GLBclk  in  1  50 MHz board clock, also the DCM CLKIN.
- reset  in  1  synchronous, active-low; low = block in reset.
- dcm_locked  in  1  DCM LOCKED_OUT; asynchronous, goes through a 2-flop synchronizer (locked_s).
- dcm_rst  out  1  DCM RST_IN, active-high.
- sys_rst_n  out  1  system reset for clkD16/clk50M logic, active-low.
- ready  out  1  high only in RUN.
- fail  out  1  sticky; high in FAIL.
- retry_cnt  out  2  timeouts in the current sequence, saturating at 3.

## Operation
- All outputs are registered. While reset=0: state=HOLD, counter=0, retry_cnt=0, synchronizer flops=0, dcm_rst=1, sys_rst_n=0, ready=0, fail=0.
- States and transitions:
  - HOLD: dcm_rst=1, sys_rst_n=0. Counts RST_HOLD_CYCLES, then goes to WAIT_LOCK with counter cleared.
  - WAIT_LOCK: dcm_rst=0. If locked_s=1, go to STABLE with counter cleared. Otherwise, when the counter reaches LOCK_TIMEOUT:
    - if retry_cnt == MAX_RETRIES, go to FAIL;
    - else retry_cnt+1 and go to HOLD.
  - STABLE: dcm_rst=0. If locked_s=0, return to WAIT_LOCK with counter cleared; the timeout restarts and retry_cnt is unchanged. After STABLE_CYCLES consecutive locked_s=1 cycles, go to RUN.
  - RUN: sys_rst_n=1, ready=1. retry_cnt clears on entry. If locked_s=0, go to HOLD. sys_rst_n=0 and ready=0 from the next cycle; dcm_rst=1.
  - FAIL: dcm_rst=1, sys_rst_n=0, fail=1. Left only by reset=0.
- Simultaneous events:
  - The lock drop in STABLE on the same cycle the counter completes takes precedence, so the state goes to WAIT_LOCK.
  - locked_s=1 on the same cycle the timeout completes takes precedence, so the state goes to STABLE.
- Counter arithmetic: unsigned, CNT_W bits, never wraps. The counter is compared against the parameters and cleared on every state change.
- retry_cnt saturates at 3; MAX_RETRIES > 3 is unsupported.
- reset=0 mid-sequence in any state, including RUN and FAIL, returns to the reset values on the next edge.

## Timing
- reset released at edge 0: dcm_rst stays 1 through edge RST_HOLD_CYCLES and reads 0 after edge RST_HOLD_CYCLES+1.
- Synchronizer latency: 2 edges from dcm_locked change to locked_s.
- Lock-to-release: if dcm_locked is first sampled high at edge k and stays high, sys_rst_n and ready read 1 after edge k+STABLE_CYCLES+3. That is 19 cycles at the default STABLE_CYCLES=16.
- Loss of lock in RUN: if dcm_locked is sampled low at edge k, sys_rst_n=0 and dcm_rst=1 after edge k+3.
- Timeout: with no lock, the WAIT_LOCK dwell is LOCK_TIMEOUT+1 cycles, then RST_HOLD_CYCLES+1 cycles of HOLD.
- Glitch filter: a dcm_locked pulse shorter than STABLE_CYCLES+1 cycles never releases sys_rst_n.

## Test plan
Benches use RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.

- Reset values: hold reset=0 for 3 cycles. Required: dcm_rst=1, sys_rst_n=0, ready=0, fail=0, retry_cnt=0 on every cycle.
- Clean lock: release reset at edge 0. Required: dcm_rst=0 from edge 5. Then raise dcm_locked at edge 10. Required: sys_rst_n=1 and ready=1 first seen after edge 21.
- Glitchy lock: dcm_locked high for 5 cycles, low for 3, then high permanently. Required: sys_rst_n stays 0 during the glitch and rises 11 edges after the final rise. retry_cnt stays 0.
- Retries to FAIL: never assert dcm_locked. Required: three WAIT_LOCK timeouts of 21 cycles each; retry_cnt reads 1, then 2; then fail=1 and dcm_rst=1 permanently. reset=0 clears fail.
- Loss of lock: reach RUN, then drop dcm_locked at edge k. Required: sys_rst_n=0 and dcm_rst=1 after edge k+3, followed by a 5-cycle HOLD. Reassert dcm_locked. Required: RUN is re-entered and retry_cnt=0.
- Reset mid-sequence: assert reset=0 during STABLE and again during RUN. Required: reset values on the next edge, and the full sequence restarts on release.
